// File: rtl/csa_serial_add_ctrl.sv
// Serial wide adder: pushes one nibble per clock through a single 4-bit
// carry-skip slice. The inter-nibble carry is held in a register.
// Control uses a start/busy/done handshake. The block also counts how many
// nibbles had all four propagate bits set, which are the nibbles that used
// the skip path.

// 4-bit carry-skip slice: ripple carry plus a bypass mux.
// The bypass is taken when every bit propagates.
module carryskip_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       skip_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Propagate/generate, ripple chain, then the skip mux on the block carry.
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum_o  = p ^ c[3:0];
    skip_o = &p;
    // When all bits propagate, the ripple result equals cin.
    // The bypass therefore cannot change the arithmetic result.
    cout_o = skip_o ? cin_i : c[4];
  end

endmodule

module csa_serial_add_ctrl #(
  parameter int NIBBLES = 4,
  parameter int CW      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic [CW-1:0]          skip_cnt
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [NIBBLES-1:0][3:0] sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic [CW-1:0]           skip_q, skip_d;
  logic [NIBBLES-1:0][3:0] a_q, b_q;

  logic       accept;
  logic [3:0] slice_sum;
  logic       slice_cout;
  logic       slice_skip;

  carryskip_adder u_slice (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .skip_o (slice_skip)
  );

  // Next-state, datapath updates and start acceptance (IDLE or DONE only).
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    skip_d  = skip_q;
    accept  = start && (state_q == S_IDLE || state_q == S_DONE);

    case (state_q)
      S_RUN: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        if (slice_skip) begin
          skip_d = skip_q + CW'(1);
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance in DONE gives back-to-back operation. Results clear here.
    // cout is not cleared and keeps its old value until the next DONE.
    if (accept) begin
      state_d = S_RUN;
      idx_d   = '0;
      carry_d = cin;
      sum_d   = '0;
      skip_d  = '0;
    end
  end

  // Control and result registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // All registers then update together from the values before the edge.
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      skip_q  <= skip_d;
    end
  end

  // Operand capture on acceptance.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers have no reset. They are always loaded
    // before RUN reads them, so a reset value would only add gates.
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign skip_cnt = skip_q;

endmodule
